// File: rtl/traffic_pkg.sv
// Shared widths, lamp bit positions, default timing and the saturating
// queue-count update used by every detector lane.
package traffic_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;

  localparam int M_L    = 3;
  localparam int M_R    = 2;
  localparam int M_Y    = 1;
  localparam int M_G    = 0;
  localparam int S_G    = 0;
  localparam int P_WALK = 0;

  localparam int DEF_DEB_CYCLES    = 4;
  localparam int DEF_DEPART_CYCLES = 8;
  localparam int DEF_HOLD_CYCLES   = 16;

  typedef enum logic [1:0] {
    EV_NONE   = 2'b00,
    EV_DEPART = 2'b01,
    EV_ARRIVE = 2'b10,
    EV_BOTH   = 2'b11
  } lane_event_e;

  // Coincident arrival and departure cancel, even at the limits.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input lane_event_e      ev);
    logic [CNT_W-1:0] res;
    res = cnt;
    case (ev)
      EV_ARRIVE: begin
        if (cnt != CNT_MAX) res = cnt + 3'd1;
        else                res = cnt;
      end
      EV_DEPART: begin
        if (cnt != 3'd0) res = cnt - 3'd1;
        else             res = cnt;
      end
      EV_BOTH: res = cnt;
      EV_NONE: res = cnt;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lane_demand_counter.sv
// One approach: synchronise and debounce the detector, time departures while
// the lane is green, and keep a saturating 0..7 queue estimate.
module lane_demand_counter
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int DEPART_CYCLES = DEF_DEPART_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_i,
  input  logic             green_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(DEPART_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(DEPART_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [DW-1:0]    deb_q, deb_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arrival_s, depart_s;

  // Debounce: a level change is accepted on the DEB_CYCLES-th mismatching cycle.
  always_comb begin
    filt_d    = filt_q;
    deb_d     = deb_q;
    arrival_s = 1'b0;
    if (sync2_q != filt_q) begin
      if (deb_q == DEB_LAST) begin
        filt_d    = sync2_q;
        deb_d     = '0;
        arrival_s = sync2_q;
      end else begin
        deb_d = deb_q + DW'(1);
      end
    end else begin
      deb_d = '0;
    end
  end

  // Departure timer: free-runs while green, cleared with no partial credit otherwise.
  always_comb begin
    tmr_d    = '0;
    depart_s = 1'b0;
    if (green_i) begin
      if (tmr_q == TMR_LAST) begin
        tmr_d    = '0;
        depart_s = 1'b1;
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end else begin
      tmr_d = '0;
    end
    cnt_d = next_count(cnt_q, lane_event_e'({arrival_s, depart_s}));
  end

  // Lane state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      deb_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= det_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      deb_q   <= deb_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_demand_sensor.sv
// Detector front end for the traffic light controller: four lane demand
// counters plus a retriggerable emergency hold on the siren detector.
module traffic_demand_sensor
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int DEPART_CYCLES = DEF_DEPART_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             main_det,
  input  logic             left_det,
  input  logic             sec_det,
  input  logic             p_btn,
  input  logic             siren_det,
  input  logic [3:0]       m_LRYG,
  input  logic [2:0]       s_RYG,
  input  logic [2:0]       p,
  output logic [CNT_W-1:0] main_num,
  output logic [CNT_W-1:0] left_num,
  output logic [CNT_W-1:0] sec_num,
  output logic [CNT_W-1:0] p_num,
  output logic             s_emergency
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);

  logic          siren_s1_q, siren_s2_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          emer_q, emer_d;
  logic          unused_lamps_s;

  // Only the green/walk/arrow bits matter for departures.
  assign unused_lamps_s = ^{m_LRYG[M_R], m_LRYG[M_Y], s_RYG[2:1], p[2:1]};

  lane_demand_counter #(.DEB_CYCLES(DEB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES)) u_main (
    .clk(clk), .rst(rst), .det_i(main_det), .green_i(m_LRYG[M_G]), .cnt_o(main_num));

  lane_demand_counter #(.DEB_CYCLES(DEB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES)) u_left (
    .clk(clk), .rst(rst), .det_i(left_det), .green_i(m_LRYG[M_L]), .cnt_o(left_num));

  lane_demand_counter #(.DEB_CYCLES(DEB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES)) u_sec (
    .clk(clk), .rst(rst), .det_i(sec_det), .green_i(s_RYG[S_G]), .cnt_o(sec_num));

  lane_demand_counter #(.DEB_CYCLES(DEB_CYCLES), .DEPART_CYCLES(DEPART_CYCLES)) u_ped (
    .clk(clk), .rst(rst), .det_i(p_btn), .green_i(p[P_WALK]), .cnt_o(p_num));

  // Emergency hold: reload while the siren is seen, otherwise count down.
  always_comb begin
    hold_d = hold_q;
    if (siren_s2_q) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end else begin
      hold_d = '0;
    end
    emer_d = (hold_d != '0);
  end

  // Siren synchroniser and hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      siren_s1_q <= 1'b0;
      siren_s2_q <= 1'b0;
      hold_q     <= '0;
      emer_q     <= 1'b0;
    end else begin
      siren_s1_q <= siren_det;
      siren_s2_q <= siren_s1_q;
      hold_q     <= hold_d;
      emer_q     <= emer_d;
    end
  end

  assign s_emergency = emer_q;

endmodule

// File: tb/tb_traffic_demand_sensor.sv
// Directed bench: table of single-pulse debounce vectors, then hand-written
// sequences for saturation, departures, collisions and emergency hold.
module tb_traffic_demand_sensor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] det_v;
  logic       siren;
  logic [3:0] m_lryg;
  logic [2:0] s_ryg;
  logic [2:0] p_lamp;
  logic [2:0] main_num, left_num, sec_num, p_num;
  logic       s_emergency;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         ch;
    int         len;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[6];

  traffic_demand_sensor dut (
    .clk(clk), .rst(rst),
    .main_det(det_v[0]), .left_det(det_v[1]), .sec_det(det_v[2]), .p_btn(det_v[3]),
    .siren_det(siren), .m_LRYG(m_lryg), .s_RYG(s_ryg), .p(p_lamp),
    .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
    .s_emergency(s_emergency));

  always #5 clk = ~clk;

  function automatic int cnt_of(input int ch);
    case (ch)
      0:       return int'(main_num);
      1:       return int'(left_num);
      2:       return int'(sec_num);
      default: return int'(p_num);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    det_v  = 4'b0000;
    siren  = 1'b0;
    m_lryg = 4'b0100;
    s_ryg  = 3'b100;
    p_lamp = 3'b100;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic pulses(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      for (int t = 1; t <= 12; t++) begin
        det_v[ch] = (t <= 6);
        tick();
      end
    end
  endtask

  initial begin
    vecs[0] = '{ch: 0, len: 10, exp: 3'd1};
    vecs[1] = '{ch: 1, len: 2,  exp: 3'd0};
    vecs[2] = '{ch: 1, len: 3,  exp: 3'd0};
    vecs[3] = '{ch: 1, len: 5,  exp: 3'd1};
    vecs[4] = '{ch: 2, len: 4,  exp: 3'd1};
    vecs[5] = '{ch: 3, len: 1,  exp: 3'd0};

    do_reset();
    for (int c = 0; c < 4; c++) chk($sformatf("reset cnt%0d", c), cnt_of(c), 0);
    chk("reset emer", int'(s_emergency), 0);

    // debounce table: arrival lands on the 6th tick after raw first sampled
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int t = 1; t <= 14; t++) begin
        det_v = 4'b0000;
        det_v[vecs[r].ch] = (t <= vecs[r].len);
        tick();
        for (int c = 0; c < 4; c++)
          chk($sformatf("vec%0d t%0d cnt%0d", r, t, c), cnt_of(c),
              (c == vecs[r].ch && t >= 6) ? int'(vecs[r].exp) : 0);
        chk($sformatf("vec%0d t%0d emer", r, t), int'(s_emergency), 0);
      end
    end

    // secondary saturation
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      pulses(2, 1);
      chk($sformatf("sat pulse%0d", k), int'(sec_num), (k < 7) ? k : 7);
    end

    // main drain under continuous green
    do_reset();
    pulses(0, 3);
    chk("drain start", int'(main_num), 3);
    m_lryg = 4'b0001;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk($sformatf("drain t%0d", t), int'(main_num), 3 - ((t / 8 > 3) ? 3 : t / 8));
    end

    // green dropped mid-period discards the partial period
    m_lryg = 4'b0100;
    pulses(0, 1);
    chk("drop start", int'(main_num), 1);
    for (int t = 1; t <= 15; t++) begin
      m_lryg = (t == 6 || t == 7) ? 4'b0100 : 4'b0001;
      tick();
      chk($sformatf("drop t%0d", t), int'(main_num), (t == 15) ? 0 : 1);
    end

    // pedestrian arrival coinciding with a departure at 7
    do_reset();
    pulses(3, 7);
    chk("ped full", int'(p_num), 7);
    for (int t = 1; t <= 12; t++) begin
      p_lamp   = 3'b001;
      det_v[3] = (t >= 3 && t <= 8);
      tick();
      chk($sformatf("ped7 t%0d", t), int'(p_num), 7);
    end

    // same collision at 0
    do_reset();
    for (int t = 1; t <= 12; t++) begin
      p_lamp   = 3'b001;
      det_v[3] = (t >= 3 && t <= 8);
      tick();
      chk($sformatf("ped0 t%0d", t), int'(p_num), 0);
    end

    // emergency hold and retrigger at hold count 3
    do_reset();
    for (int t = 1; t <= 36; t++) begin
      siren = (t == 1 || t == 15);
      tick();
      chk($sformatf("emer t%0d", t), int'(s_emergency), (t >= 3 && t <= 32) ? 1 : 0);
    end

    // async reset mid-hold, then a detector already high at release
    pulses(0, 1);
    siren = 1'b1;
    tick();
    siren = 1'b0;
    tick();
    tick();
    chk("pre-rst main", int'(main_num), 1);
    chk("pre-rst emer", int'(s_emergency), 1);
    det_v[0] = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("async rst main", int'(main_num), 0);
    chk("async rst emer", int'(s_emergency), 0);
    tick();
    tick();
    rst = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk($sformatf("post-rst t%0d", t), int'(main_num), (t >= 6) ? 1 : 0);
      chk($sformatf("post-rst emer t%0d", t), int'(s_emergency), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
